// File: rtl/ir_pkg.sv
// Shared types and timing constants for the NEC infrared decoder.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_L,
    LEAD_H,
    BIT_L,
    BIT_H,
    CHECK,
    ERR
  } ir_dec_state_t;

  // Phase windows in microseconds; the decoder scales them by CLK_PER_US.
  localparam int unsigned LEAD_L_MIN_US = 8000;
  localparam int unsigned LEAD_L_MAX_US = 10000;
  localparam int unsigned LEAD_H_MIN_US = 4000;
  localparam int unsigned LEAD_H_MAX_US = 5000;
  localparam int unsigned REP_H_MIN_US  = 2000;
  localparam int unsigned REP_H_MAX_US  = 2500;
  localparam int unsigned BIT_L_MIN_US  = 400;
  localparam int unsigned BIT_L_MAX_US  = 700;
  localparam int unsigned BIT0_H_MIN_US = 400;
  localparam int unsigned BIT0_H_MAX_US = 700;
  localparam int unsigned BIT1_H_MIN_US = 1500;
  localparam int unsigned BIT1_H_MAX_US = 1900;
  localparam int unsigned SAT_US        = 11000;

  localparam logic [7:0] IR_IDLE_CODE = 8'hFF;

  // Inclusive window test on a phase count.
  function automatic logic in_win(input logic [31:0] c, input int unsigned lo,
                                  input int unsigned hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_decoder_sync_edge.sv
// Two-flop synchroniser for the IR pin plus a registered-previous edge detector.
module ir_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic rx_prev;

  // Synchronise the pin and keep the previous synchronised level; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      meta    <= rx;
      rx_s    <= meta;
      rx_prev <= rx_s;
    end
  end

  assign rise = rx_s & ~rx_prev;
  assign fall = ~rx_s & rx_prev;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: phase counter, frame FSM and registered outputs.
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50,
  parameter logic [7:0]  IDLE_CODE  = IR_IDLE_CODE
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        IRDA_RXD,
  output logic [31:0] hex_data,
  output logic [7:0]  IR_button,
  output logic        ir_valid,
  output logic        ir_repeat,
  output logic        frame_error
);

  localparam int unsigned SAT_CYC = SAT_US * CLK_PER_US;
  localparam int unsigned CW      = $clog2(SAT_CYC);

  localparam int unsigned LL_MIN = LEAD_L_MIN_US * CLK_PER_US;
  localparam int unsigned LL_MAX = LEAD_L_MAX_US * CLK_PER_US;
  localparam int unsigned LH_MIN = LEAD_H_MIN_US * CLK_PER_US;
  localparam int unsigned LH_MAX = LEAD_H_MAX_US * CLK_PER_US;
  localparam int unsigned RH_MIN = REP_H_MIN_US  * CLK_PER_US;
  localparam int unsigned RH_MAX = REP_H_MAX_US  * CLK_PER_US;
  localparam int unsigned BL_MIN = BIT_L_MIN_US  * CLK_PER_US;
  localparam int unsigned BL_MAX = BIT_L_MAX_US  * CLK_PER_US;
  localparam int unsigned B0_MIN = BIT0_H_MIN_US * CLK_PER_US;
  localparam int unsigned B0_MAX = BIT0_H_MAX_US * CLK_PER_US;
  localparam int unsigned B1_MIN = BIT1_H_MIN_US * CLK_PER_US;
  localparam int unsigned B1_MAX = BIT1_H_MAX_US * CLK_PER_US;

  localparam logic [CW-1:0] SAT_CNT = CW'(SAT_CYC);

  logic rx_s;
  logic rise;
  logic fall;

  logic [CW-1:0] cnt;
  logic [31:0]   cnt_w;

  ir_dec_state_t state, state_d;
  logic [4:0]    idx, idx_d;
  logic [31:0]   shift, shift_d;
  logic          valid_d, repeat_d, err_d;

  ir_sync_edge u_sync (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .rx    (IRDA_RXD),
    .rx_s  (rx_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign cnt_w = 32'(cnt);

  // Phase length counter: restarts on every synchronised edge, saturates when the line stalls.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (rise || fall) begin
      cnt <= '0;
    end else if (cnt < SAT_CNT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // FSM state, bit index and shift register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      shift <= shift_d;
    end
  end

  // Next-state logic: each phase is judged at its closing edge or on overrun of its window.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    shift_d  = shift;
    valid_d  = 1'b0;
    repeat_d = 1'b0;
    err_d    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_d = LEAD_L;
      end
      LEAD_L: begin
        if (rise) begin
          state_d = in_win(cnt_w, LL_MIN, LL_MAX) ? LEAD_H : IDLE;
        end else if (!rx_s && cnt_w > LL_MAX) begin
          state_d = IDLE;
        end
      end
      LEAD_H: begin
        if (fall) begin
          if (in_win(cnt_w, LH_MIN, LH_MAX)) begin
            idx_d   = '0;
            state_d = BIT_L;
          end else if (in_win(cnt_w, RH_MIN, RH_MAX)) begin
            repeat_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = IDLE;
          end
        end else if (rx_s && cnt_w > LH_MAX) begin
          state_d = IDLE;
        end
      end
      BIT_L: begin
        if (rise) begin
          state_d = in_win(cnt_w, BL_MIN, BL_MAX) ? BIT_H : ERR;
        end else if (!rx_s && cnt_w > BL_MAX) begin
          state_d = ERR;
        end
      end
      BIT_H: begin
        if (fall) begin
          if (in_win(cnt_w, B0_MIN, B0_MAX) || in_win(cnt_w, B1_MIN, B1_MAX)) begin
            shift_d[idx] = in_win(cnt_w, B1_MIN, B1_MAX);
            if (idx == 5'd31) begin
              state_d = CHECK;
            end else begin
              idx_d   = idx + 5'd1;
              state_d = BIT_L;
            end
          end else begin
            state_d = ERR;
          end
        end else if (rx_s && cnt_w > B1_MAX) begin
          state_d = ERR;
        end
      end
      CHECK: begin
        if (shift[31:24] == ~shift[23:16]) valid_d = 1'b1;
        else                               err_d   = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: strobes last one cycle, the frame word is held between valid frames.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      hex_data    <= '0;
      IR_button   <= IDLE_CODE;
      ir_valid    <= 1'b0;
      ir_repeat   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (valid_d) hex_data <= shift;
      IR_button   <= valid_d ? shift[23:16] : IDLE_CODE;
      ir_valid    <= valid_d;
      ir_repeat   <= repeat_d;
      frame_error <= err_d;
    end
  end

endmodule

// File: doc/ir_nec_decoder.md
# ir_nec_decoder

Decodes the NEC-format infrared frame from the IR receiver pin into the 32-bit `hex_data` word and a one-cycle button strobe. It is the producer side of the `IR_button` / `hex_data[23:16]` interface consumed by the drive-mode FSM. The block sits between the top-level `IRDA_RXD` pin and that FSM. It only reports a button code after the frame's timing and the command-inverse checks have passed.

## Interface
Parameters:
- `CLK_PER_US`, 50: clock cycles per microsecond. All timing windows scale by this value; benches use 1.
- `IDLE_CODE`, 8'hFF: value driven on `IR_button` whenever `ir_valid` is low.

Ports:
- `CLOCK_50` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `IRDA_RXD` in 1: raw receiver output. Idle is high; a carrier burst reads low. Asynchronous to `CLOCK_50`.
- `hex_data` out 32: last valid frame, held. Layout: [7:0] address, [15:8] address or ~address, [23:16] command, [31:24] ~command.
- `IR_button` out 8: command byte during the `ir_valid` cycle, `IDLE_CODE` otherwise.
- `ir_valid` out 1: one-cycle strobe when a valid frame completes.
- `ir_repeat` out 1: one-cycle strobe when a repeat frame is recognised.
- `frame_error` out 1: one-cycle strobe when a started frame is aborted.

## Operation
- `IRDA_RXD` passes through a 2-FF synchroniser to give `rx_s`, then an edge detector with a registered `rx_s` previous value.
- Phase counter: cleared on every `rx_s` edge, otherwise increments and saturates at 11000·`CLK_PER_US`. Width is `$clog2` of that value.
- Windows are in µs, each multiplied by `CLK_PER_US`. Each phase is judged at its closing edge:
  - Leader low: 8000–10000.
  - Leader high, data frame: 4000–5000.
  - Leader high, repeat frame: 2000–2500.
  - Bit low: 400–700.
  - Bit high for a 0: 400–700.
  - Bit high for a 1: 1500–1900.
- States:
  - IDLE: a falling edge goes to LEAD_L.
  - LEAD_L: at the rising edge, an in-window count goes to LEAD_H; otherwise IDLE silently.
  - LEAD_H: at the falling edge, the 4500 window clears the bit index and goes to BIT_L. The 2250 window pulses `ir_repeat` and goes to IDLE. Anything else goes to IDLE silently.
  - BIT_L: at the rising edge, in-window goes to BIT_H; otherwise ERR.
  - BIT_H: at the falling edge, the count is classified as 0 or 1 and written to `shift[idx]` (LSB first). Then idx==31 goes to CHECK, else idx++ and BIT_L. An out-of-window count goes to ERR.
  - CHECK (one cycle): if `shift[31:24] == ~shift[23:16]`, load `hex_data`, pulse `ir_valid`, and drive `IR_button = shift[23:16]`. Otherwise pulse `frame_error`. In both cases go to IDLE.
  - ERR (one cycle): pulse `frame_error`, go to IDLE.
- Timeout: if the counter passes the current phase's window maximum before the closing edge, act as if an out-of-window edge arrived. In LEAD states that means IDLE silently; in BIT states it means ERR.
- The address byte is not checked; extended NEC is allowed.
- The stop burst after bit 31 is absorbed: its rising edge is ignored in IDLE. Its leader-low duration can never match the 8000–10000 window.
- A falling edge in the same cycle as CHECK or ERR is lost. This is acceptable because the stop burst covers it.
- Reset values: `hex_data` = 0, `IR_button` = `IDLE_CODE`, all strobes 0, state IDLE, counter 0. The synchroniser flops reset to 1.
- Reset mid-frame discards the partial frame. No strobe is produced.

## Timing
- Latency from the pin's final falling edge (the start of the stop burst) to the `ir_valid` cycle:
  - 2 cycles through the synchroniser.
  - 1 cycle in which the edge is detected and BIT_H moves to CHECK.
  - Strobe asserted in the next cycle.
  - Total: 4 `CLOCK_50` edges.
- `ir_repeat` and `frame_error` are registered. They assert one cycle after the qualifying `rx_s` edge.
- All strobes are exactly one cycle wide and are never asserted together.
- `hex_data` changes only in the `ir_valid` cycle and holds otherwise.

## Structure
- Package `ir_pkg`:
  - State enum `ir_dec_state_t` {IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, CHECK, ERR}.
  - µs constants for every window bound and the saturation limit.
  - Default `IDLE_CODE`.
- Sub-module `ir_sync_edge`: 2-FF synchroniser plus edge detector, with outputs `rx_s`, `rise`, `fall`. The top module holds the counter, the FSM and the output registers.

## Test plan
All scenarios run with `CLK_PER_US`=1.
- Valid frame, address 8'h00, command 8'h1A: `ir_valid` pulses once, 4 cycles after the stop-burst fall. `IR_button` = 8'h1A in that cycle and 8'hFF otherwise. `hex_data` = 32'hE51A_FF00.
- Repeat frame (9000 low, 2250 high, 560 low) after the frame above: `ir_repeat` pulses once. `hex_data` is unchanged and there is no `ir_valid`.
- Frame with command 8'h0F and an inverse byte of 8'hF1 (bad): `frame_error` pulses once. `hex_data` keeps its previous value and there is no `ir_valid`.
- Bit-5 high phase stretched to 1000: `frame_error` pulses when the window closes. A following valid frame with command 8'h13 decodes normally.
- Pin held low for 20000 after a leader: the block returns silently to IDLE with no strobe. A 300-cycle glitch low produces no strobe.
- `reset_n` asserted at bit 16: all outputs return to reset values immediately. No strobe follows. The next full frame decodes.
